// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          func3_q, func3_d;
    logic [XLEN-1:0]     mag_a_q, mag_a_d;
    logic [XLEN-1:0]     mag_b_q, mag_b_d;
    logic                neg_prod_q, neg_prod_d;
    logic                neg_dvd_q, neg_dvd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                div_zero, div_ovf;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       trial;
    logic                trial_ge;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (func3)
            3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
        sa       = a_signed & a[XLEN-1];
        sb       = b_signed & b[XLEN-1];
        abs_a    = sa ? -a : a;
        abs_b    = sb ? -b : b;
        div_zero = func3[2] & (b == '0);
        div_ovf  = func3[2] & ~func3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);

        // Datapath for one iteration and for the final sign correction.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        trial    = {rem_q, acc_q[XLEN-1]};
        trial_ge = (trial >= {1'b0, mag_b_q});
        prod_fix = neg_prod_q ? -acc_q : acc_q;
        quot_fix = neg_prod_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_dvd_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        func3_d    = func3_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        neg_prod_d = neg_prod_q;
        neg_dvd_d  = neg_dvd_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    func3_d    = func3;
                    mag_a_d    = abs_a;
                    mag_b_d    = abs_b;
                    neg_prod_d = sa ^ sb;
                    neg_dvd_d  = sa;
                    cnt_d      = '0;
                    rem_d      = '0;
                    acc_d      = {{XLEN{1'b0}}, (func3[2] ? abs_a : abs_b)};
                    state_d    = ITER;
                    // Special divides preload the final quotient/remainder and skip ITER.
                    if (div_zero) begin
                        acc_d      = {{XLEN{1'b0}}, {XLEN{1'b1}}};
                        rem_d      = a;
                        neg_prod_d = 1'b0;
                        neg_dvd_d  = 1'b0;
                        state_d    = FIX;
                    end else if (div_ovf) begin
                        acc_d      = {{XLEN{1'b0}}, a};
                        rem_d      = '0;
                        neg_prod_d = 1'b0;
                        neg_dvd_d  = 1'b0;
                        state_d    = FIX;
                    end
                end
            end
            ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (func3_q[2]) begin
                    rem_d = trial_ge ? XLEN'(trial - {1'b0, mag_b_q}) : trial[XLEN-1:0];
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], trial_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                case (func3_q)
                    3'b000:                 result_d = prod_fix[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
                    3'b100, 3'b101:         result_d = quot_fix;
                    default:                result_d = rem_fix;
                endcase
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            func3_q    <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            neg_prod_q <= 1'b0;
            neg_dvd_q  <= 1'b0;
            acc_q      <= '0;
            rem_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            func3_q    <= func3_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            neg_prod_q <= neg_prod_d;
            neg_dvd_q  <= neg_dvd_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN = 32): vector table plus
// hand-written handshake and mid-operation reset sequences.
module tb_muldiv_unit;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] last_exp = '0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .func3(func3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1;
        func3 = f3;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of cycle 1; returns at the negedge after the done cycle.
    task automatic wait_done(input string name, input int exp_cycle, input logic [31:0] exp_res);
        int done_cyc = -1;
        int busy_bad = 0;
        int hold_bad = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (result !== last_exp) hold_bad++;
        end
        check_output({name, " done cycle"}, 32'(done_cyc), 32'(exp_cycle));
        check_output({name, " busy low early"}, 32'(busy_bad), 32'd0);
        check_output({name, " result not held"}, 32'(hold_bad), 32'd0);
        check_output({name, " result"}, result, exp_res);
        last_exp = exp_res;
        @(negedge clk);
        check_output({name, " busy/done after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        vecs.push_back('{"mul 7*-3",        F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34});
        vecs.push_back('{"mul shift",       F_MUL,    32'h12345678, 32'h10,       32'h23456780, 34});
        vecs.push_back('{"mulh min*min",    F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34});
        vecs.push_back('{"mulh -1*-1",      F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34});
        vecs.push_back('{"mulh 7*-2",       F_MULH,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 34});
        vecs.push_back('{"mulhu max*max",   F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
        vecs.push_back('{"mulhu 2^31*4",    F_MULHU,  32'h80000000, 32'd4,        32'h00000002, 34});
        vecs.push_back('{"mulhsu -1*max",   F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
        vecs.push_back('{"divu 100/7",      F_DIVU,   32'd100,      32'd7,        32'd14,       34});
        vecs.push_back('{"remu 100/7",      F_REMU,   32'd100,      32'd7,        32'd2,        34});
        vecs.push_back('{"divu max/16",     F_DIVU,   32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 34});
        vecs.push_back('{"remu max/16",     F_REMU,   32'hFFFFFFFF, 32'h10,       32'h0000000F, 34});
        vecs.push_back('{"div -7/2",        F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
        vecs.push_back('{"rem -7/2",        F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
        vecs.push_back('{"rem 7/-2",        F_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34});
        vecs.push_back('{"div 7/-2",        F_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34});
        vecs.push_back('{"rem -8/-3",       F_REM,    32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 34});
        vecs.push_back('{"div min/1",       F_DIV,    32'h80000000, 32'd1,        32'h80000000, 34});
        vecs.push_back('{"divu 2^31/max",   F_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34});
        vecs.push_back('{"remu 2^31/max",   F_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34});
        vecs.push_back('{"div 5/0",         F_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 2});
        vecs.push_back('{"rem 5/0",         F_REM,    32'd5,        32'd0,        32'd5,        2});
        vecs.push_back('{"divu 5/0",        F_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2});
        vecs.push_back('{"remu 2^31/0",     F_REMU,   32'h80000000, 32'd0,        32'h80000000, 2});
        vecs.push_back('{"div ovf",         F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
        vecs.push_back('{"rem ovf",         F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2});

        repeat (2) @(negedge clk);
        check_output("reset outputs", {busy, done, result[29:0]} | {32'd0, result[31:30]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("idle after reset", {30'd0, busy, done}, 32'd0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].f3, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].name, vecs[i].cyc, vecs[i].exp);
        end

        // start held high with operands scrambled during the op, then a back-to-back DIVU
        @(negedge clk);
        start = 1'b1;
        func3 = F_MUL;
        a     = 32'd3;
        b     = 32'd5;
        @(negedge clk);
        fork
            wait_done("held start mul", 34, 32'd15);
            begin
                for (int k = 1; k <= 33; k++) begin
                    a     = $urandom;
                    b     = $urandom;
                    func3 = 3'($urandom);
                    @(negedge clk);
                end
            end
        join
        func3 = F_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("back-to-back divu", 34, 32'd14);

        apply_stimulus(F_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        check_output("busy before reset", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_output("async reset busy/done", {30'd0, busy, done}, 32'd0);
        check_output("async reset result", result, 32'd0);
        #1 rst = 1'b0;
        last_exp = '0;
        begin
            int done_cnt = 0;
            for (int k = 0; k < 45; k++) begin
                @(negedge clk);
                if (done === 1'b1) done_cnt++;
            end
            check_output("no done after reset", 32'(done_cnt), 32'd0);
        end
        apply_stimulus(F_MUL, 32'd3, 32'd4);
        wait_done("mul after reset", 34, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit, parametrised in datapath width, implementing all eight RISC-V M-extension operations. It hangs off the multi-cycle core's datapath next to the ALU. The core's controller raises `start` in its execute state, stalls while `busy`, and writes `result` back on `done`. Results are bit-exact with the RV32M/RV64M rules, including the divide-by-zero and signed-overflow cases.

## Interface
- XLEN, 32, operand/result width; legal values ≥ 4
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- func3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand (dividend / multiplicand)
- b  in  XLEN  rs2 operand (divisor / multiplier)
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; result valid
- result  out  XLEN  registered result; held until the next accepted start

## Operation
- **States:** IDLE, ITER, FIX, DONE.
- **Start acceptance:** in IDLE with `start`=1, the unit latches func3, a and b. Operand and func3 changes after that edge are ignored.
- **Signedness:**
  - a is signed for MULH, MULHSU, DIV and REM.
  - b is signed for MULH, DIV and REM.
  - MUL uses unsigned magnitudes; its low word is identical either way.
- **Operand conditioning:** the unit stores |a|, |b|, the product sign (sa XOR sb) and the dividend sign.
- **Special cases:** detected at the accept edge; these go IDLE→FIX directly.
  - Divisor zero: quotient = all ones (−1). Remainder = a.
  - Signed overflow (DIV/REM, a = most negative, b = −1): quotient = a. Remainder = 0.
  - Otherwise the unit goes IDLE→ITER with the iteration counter at 0.
- **Multiply (ITER):** shift-add on magnitudes, one multiplier bit per cycle, into a 2·XLEN accumulator. XLEN iterations.
- **Divide (ITER):** restoring division on magnitudes, one quotient bit per cycle, with an XLEN+1-bit partial remainder. XLEN iterations.
- **Counter:** ⌈log2 XLEN⌉ bits. ITER→FIX when the counter = XLEN−1.
- **FIX:** applies two's-complement negation where required, then writes `result` and goes to DONE.
  - MUL returns the low word. MULH/MULHSU/MULHU return the high word.
  - Quotient is negated if the signs differ (signed ops). Remainder takes the dividend's sign.
- **DONE:** asserts `done` for exactly one cycle, then returns to IDLE.
- **start outside IDLE:** ignored, no queueing. The controller must wait for `done`.
- **Reset (async, any state, including mid-ITER):**
  - state = IDLE, busy = 0, done = 0, result = 0, counter = 0.
  - The aborted operation produces no `done`.

## Timing
- Cycle 0 = the cycle in which `start` is sampled high in IDLE.
- **Normal ops:**
  - busy is high in cycles 1 … XLEN+2.
  - done and the new result appear in cycle XLEN+2 (34 for XLEN = 32).
  - A new start is accepted in cycle XLEN+3 at the earliest.
- **Special cases:**
  - busy is high in cycles 1–2.
  - done appears in cycle 2.
- **result:** changes only on the FIX→DONE edge and is stable while done = 1.
- **Outputs:** all are registered; no combinational input→output path.

## Test plan
- **Multiply, low and high words:** MUL a=7, b=0xFFFFFFFD → result 0xFFFFFFEB, done in cycle 34 only. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- **Mixed signedness:** MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- **Signed divide rounding and remainder sign:** DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. REM 7/−2 → 1.
- **Special cases:** DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIV 0x80000000/−1 → 0x80000000, REM 0x80000000/−1 → 0. Each must give done in cycle 2.
- **Handshake:** start held high plus operand changes in cycles 1–33 are ignored and the result matches the latched operands. Back-to-back start in cycle 35 is accepted. The previous result holds until the next FIX→DONE edge.
- **Reset mid-operation:** rst pulsed in cycle 10 of a DIV → busy, done and result drop to 0 immediately and no done follows. A subsequent MUL 3×4 → 12 in cycle 34 of that request.
